// File: rtl/axi_master_port_pkg.sv
// Shared AXI field constants and master FSM state type for axi_master_port.
package axi_master_port_pkg;

    localparam int unsigned AXI_ID_BITS   = 4;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam logic [3:0] AXI_LEN_ONE   = 4'd0;
    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;
    localparam logic [1:0] AXI_BURST_INC = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WADDR_DATA,
        S_WRESP
    } master_state_e;

endpackage

// File: rtl/axi_master_port_if.sv
// AR/R/AW/W/B channel bundle between an AXI initiator and the interconnect.
interface axi_master_port_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import axi_master_port_pkg::*;

    logic [AXI_ID_BITS-1:0] ARID;
    logic [ADDR_W-1:0]      ARADDR;
    logic [3:0]             ARLEN;
    logic [2:0]             ARSIZE;
    logic [1:0]             ARBURST;
    logic                   ARVALID;
    logic                   ARREADY;

    logic [AXI_ID_BITS-1:0] RID;
    logic [DATA_W-1:0]      RDATA;
    logic [1:0]             RRESP;
    logic                   RLAST;
    logic                   RVALID;
    logic                   RREADY;

    logic [AXI_ID_BITS-1:0] AWID;
    logic [ADDR_W-1:0]      AWADDR;
    logic [3:0]             AWLEN;
    logic [2:0]             AWSIZE;
    logic [1:0]             AWBURST;
    logic                   AWVALID;
    logic                   AWREADY;

    logic [DATA_W-1:0]      WDATA;
    logic [DATA_W/8-1:0]    WSTRB;
    logic                   WLAST;
    logic                   WVALID;
    logic                   WREADY;

    logic [AXI_ID_BITS-1:0] BID;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/axi_master_port.sv
// Single-outstanding AXI4 initiator: one CPU/DMA word request becomes one
// single-beat AXI read or write, completed by a one-cycle rsp_valid pulse.
module axi_master_port
    import axi_master_port_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0,
    parameter int unsigned            ADDR_W    = 32,
    parameter int unsigned            DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,

    axi_master_port_if.master   axi
);

    localparam int unsigned STRB_W = DATA_W / 8;

    master_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              unused_axi;

    // Bus drive: VALID/READY come from state and done flags only, never from the peer's READY
    always_comb begin
        req_ready   = (state_q == S_IDLE);

        axi.ARID    = MASTER_ID;
        axi.ARADDR  = addr_q;
        axi.ARLEN   = AXI_LEN_ONE;
        axi.ARSIZE  = AXI_SIZE_WORD;
        axi.ARBURST = AXI_BURST_INC;
        axi.ARVALID = (state_q == S_RADDR);
        axi.RREADY  = (state_q == S_RDATA);

        axi.AWID    = MASTER_ID;
        axi.AWADDR  = addr_q;
        axi.AWLEN   = AXI_LEN_ONE;
        axi.AWSIZE  = AXI_SIZE_WORD;
        axi.AWBURST = AXI_BURST_INC;
        axi.AWVALID = (state_q == S_WADDR_DATA) && !aw_done_q;

        axi.WDATA   = wdata_q;
        axi.WSTRB   = wstrb_q;
        axi.WLAST   = 1'b1;
        axi.WVALID  = (state_q == S_WADDR_DATA) && !w_done_q;

        axi.BREADY  = (state_q == S_WRESP);

        rsp_valid   = rsp_valid_q;
        rsp_rdata   = rsp_rdata_q;
        rsp_err     = rsp_err_q;
    end

    // IDs and RLAST carry no information with a single outstanding single-beat transfer
    always_comb unused_axi = ^{axi.RID, axi.RLAST, axi.BID};

    // Next-state: request capture, channel handshakes and completion reporting
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write ? S_WADDR_DATA : S_RADDR;
                end
            end
            S_RADDR: begin
                if (axi.ARVALID && axi.ARREADY) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (axi.RVALID && axi.RREADY) begin
                    rsp_rdata_d = axi.RDATA;
                    rsp_err_d   = (axi.RRESP != AXI_RESP_OKAY);
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WADDR_DATA: begin
                // Flags fold in this cycle's handshakes so the last one completing moves on at once
                aw_done_d = aw_done_q || (axi.AWVALID && axi.AWREADY);
                w_done_d  = w_done_q || (axi.WVALID && axi.WREADY);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WRESP;
                end
            end
            S_WRESP: begin
                if (axi.BVALID && axi.BREADY) begin
                    rsp_err_d   = (axi.BRESP != AXI_RESP_OKAY);
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and capture registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
